// File: rtl/mem_access_sequencer_if.sv
// RAM-side bus of the memory access sequencer: registered address, write
// data and write strobe toward a 16x4 synchronous RAM, read data back.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/mem_access_sequencer.sv
// Keypad/timer driven RAM sequencer: two-key write session with timeout and
// read-back, or a timed wrapping scan of the RAM shown on the display.
module mem_access_sequencer #(
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 4,
  parameter int SCAN_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dav,
  input  logic [3:0]            DataIn,
  input  logic                  TimerTrigger,
  input  logic                  mode,
  mem_access_sequencer_if.master mem,
  output logic [ADDR_W-1:0]     disp_addr,
  output logic [DATA_W-1:0]     disp_data,
  output logic                  disp_valid,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  localparam int MAXT  = (SCAN_TICKS > TIMEOUT_TICKS) ? SCAN_TICKS : TIMEOUT_TICKS;
  localparam int CNT_W = $clog2(MAXT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_DATA   = 3'd1,
    W_COMMIT = 3'd2,
    R_ISSUE  = 3'd3,
    R_LATCH  = 3'd4,
    R_HOLD   = 3'd5
  } state_t;

  logic              dav_s1_q, dav_s2_q, dav_s3_q;
  logic [3:0]        key_q;
  logic              key_evt;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              scan_q, scan_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              err_q, err_d;

  // dav is asynchronous: two-flop synchronizer plus an edge flop; the key
  // code is captured alongside sync2 so it lines up with key_evt.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dav_s1_q <= 1'b0;
      dav_s2_q <= 1'b0;
      dav_s3_q <= 1'b0;
      key_q    <= '0;
    end else begin
      dav_s1_q <= dav;
      dav_s2_q <= dav_s1_q;
      dav_s3_q <= dav_s2_q;
      key_q    <= DataIn;
    end
  end

  assign key_evt = dav_s2_q & ~dav_s3_q;

  // State and all output registers; reset also kills an in-flight write strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      scan_q       <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      scan_q       <= scan_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      err_q        <= err_d;
    end
  end

  // Next-state and next-output decode. mem_addr is loaded on entry to
  // W_COMMIT/R_ISSUE so it is already stable during those cycles. A key
  // event always takes priority over a coincident timer tick.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    scan_d       = scan_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_evt) begin
          addr_d = ADDR_W'(key_q);
          if (!mode) begin
            state_d = W_DATA;
            cnt_d   = '0;
          end else begin
            state_d    = R_ISSUE;
            scan_d     = 1'b1;
            mem_addr_d = ADDR_W'(key_q);
          end
        end
      end
      W_DATA: begin
        if (key_evt) begin
          state_d     = W_COMMIT;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = DATA_W'(key_q);
        end else if (TimerTrigger) begin
          if (cnt_q == TMO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      W_COMMIT: begin
        state_d = R_ISSUE;
        scan_d  = 1'b0;
      end
      R_ISSUE: state_d = R_LATCH;
      R_LATCH: begin
        disp_addr_d  = addr_q;
        disp_data_d  = mem.mem_rdata;
        disp_valid_d = 1'b1;
        if (scan_q) begin
          state_d = R_HOLD;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      R_HOLD: begin
        if (key_evt) begin
          state_d = IDLE;
        end else if (TimerTrigger) begin
          if (cnt_q == SCAN_LAST) begin
            addr_d     = addr_q + 1'b1;
            mem_addr_d = addr_q + 1'b1;
            state_d    = R_ISSUE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign disp_addr     = disp_addr_q;
  assign disp_data     = disp_data_q;
  assign disp_valid    = disp_valid_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural 16x4 sync RAM.
module tb_mem_access_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dav = 1'b0;
  logic [3:0] DataIn = 4'h0;
  logic       TimerTrigger = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] disp_addr, disp_data;
  logic       disp_valid, busy, err;
  logic [2:0] state_dbg;

  mem_access_sequencer_if #(.ADDR_W(4), .DATA_W(4)) mem_if ();

  mem_access_sequencer #(.ADDR_W(4), .DATA_W(4), .SCAN_TICKS(4), .TIMEOUT_TICKS(8)) dut (
    .clock(clock), .reset(reset), .dav(dav), .DataIn(DataIn),
    .TimerTrigger(TimerTrigger), .mode(mode), .mem(mem_if),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // RAM model, preloaded with data = ~addr while reset is held
  logic [3:0] ram [16];
  logic [3:0] ram_rdata;
  assign mem_if.mem_rdata = ram_rdata;
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 4'(~i);
    end else if (mem_if.mem_we === 1'b1) begin
      ram[mem_if.mem_addr] <= mem_if.mem_wdata;
    end
    ram_rdata <= ram[mem_if.mem_addr];
  end

  // Strobe monitor: counts write and error cycles
  int         we_cnt = 0, err_cnt = 0;
  logic [3:0] last_we_addr = 4'h0, last_we_data = 4'h0;
  always @(posedge clock) begin
    if (mem_if.mem_we === 1'b1) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= mem_if.mem_addr;
      last_we_data <= mem_if.mem_wdata;
    end
    if (err === 1'b1) err_cnt <= err_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] c, input int hold);
    @(negedge clock);
    DataIn = c;
    dav    = 1'b1;
    repeat (hold) @(negedge clock);
    dav = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      TimerTrigger = 1'b1;
      @(negedge clock);
      TimerTrigger = 1'b0;
    end
  endtask

  // Data key held two edges, then waits (bounded) for the write strobe
  task automatic data_key_until_we(input logic [3:0] c, output logic seen);
    seen = 1'b0;
    @(negedge clock);
    DataIn = c;
    dav    = 1'b1;
    @(negedge clock);
    @(negedge clock);
    dav = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      if (mem_if.mem_we === 1'b1) seen = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] exp_addr;
    logic [3:0] exp_data;
  } wvec_t;

  typedef struct {
    logic [3:0] exp_addr;
    logic [3:0] exp_data;
  } svec_t;

  wvec_t wv[5];
  svec_t sv[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   w0, e0;
    logic seen;

    wv[0] = '{4'h5, 4'hA, 4'h5, 4'hA};
    wv[1] = '{4'hF, 4'h3, 4'hF, 4'h3};
    wv[2] = '{4'h0, 4'h0, 4'h0, 4'h0};
    wv[3] = '{4'h5, 4'h6, 4'h5, 4'h6};
    wv[4] = '{4'hC, 4'hF, 4'hC, 4'hF};
    sv[0] = '{4'hE, 4'h1};
    sv[1] = '{4'hF, 4'h0};
    sv[2] = '{4'h0, 4'hF};

    // Reset held 3 cycles with dav toggling
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      dav = ~dav;
    end
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 4'h0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 4'h0);
    chk("rst_mem_we", mem_if.mem_we, 1'b0);
    chk("rst_disp_addr", disp_addr, 4'h0);
    chk("rst_disp_data", disp_data, 4'h0);
    chk("rst_disp_valid", disp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    dav   = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_release_state", state_dbg, 3'd0);
    chk("rst_no_we", we_cnt, 0);

    // Scan from E with wrap
    mode = 1'b1;
    press(4'hE, 3);
    for (int i = 0; i < 3; i++) begin
      chk("scan_addr", disp_addr, sv[i].exp_addr);
      chk("scan_data", disp_data, sv[i].exp_data);
      chk("scan_valid", disp_valid, 1'b1);
      chk("scan_state_hold", state_dbg, 3'd5);
      tick(3);
      chk("scan_held_addr", disp_addr, sv[i].exp_addr);
      chk("scan_held_state", state_dbg, 3'd5);
      if (i < 2) begin
        tick(1);
        repeat (2) @(negedge clock);
      end
    end
    press(4'h7, 3);
    chk("scan_abort_state", state_dbg, 3'd0);
    chk("scan_abort_addr", disp_addr, 4'h0);
    chk("scan_abort_data", disp_data, 4'hF);
    chk("scan_abort_valid", disp_valid, 1'b1);

    // R_HOLD: key and 4th tick together -> abort, no advance
    mode = 1'b1;
    press(4'h2, 3);
    chk("rh_disp_data", disp_data, 4'hD);
    tick(3);
    @(negedge clock); DataIn = 4'h9; dav = 1'b1;
    @(negedge clock);
    @(negedge clock); TimerTrigger = 1'b1;
    @(negedge clock); TimerTrigger = 1'b0; dav = 1'b0;
    repeat (4) @(negedge clock);
    chk("rh_simul_state", state_dbg, 3'd0);
    chk("rh_simul_mem_addr", mem_if.mem_addr, 4'h2);
    chk("rh_simul_disp_addr", disp_addr, 4'h2);
    chk("rh_simul_disp_data", disp_data, 4'hD);

    // Write + read-back table
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w0 = we_cnt;
      press(wv[i].a, 3);
      chk("wr_in_wdata_state", state_dbg, 3'd1);
      press(wv[i].d, 3);
      chk("wr_we_pulses", we_cnt - w0, 1);
      chk("wr_we_addr", last_we_addr, wv[i].exp_addr);
      chk("wr_we_data", last_we_data, wv[i].exp_data);
      chk("wr_disp_addr", disp_addr, wv[i].exp_addr);
      chk("wr_disp_data", disp_data, wv[i].exp_data);
      chk("wr_disp_valid", disp_valid, 1'b1);
      chk("wr_end_state", state_dbg, 3'd0);
    end

    // Timeout after 8 ticks
    mode = 1'b0;
    w0 = we_cnt;
    e0 = err_cnt;
    press(4'h3, 3);
    tick(7);
    chk("tmo_state_7", state_dbg, 3'd1);
    chk("tmo_err_7", err, 1'b0);
    tick(1);
    chk("tmo_err_8", err, 1'b1);
    chk("tmo_state_8", state_dbg, 3'd0);
    @(negedge clock);
    chk("tmo_err_drop", err, 1'b0);
    chk("tmo_err_pulses", err_cnt - e0, 1);
    chk("tmo_no_we", we_cnt - w0, 0);

    // W_DATA: data key and 8th tick together -> write wins
    w0 = we_cnt;
    e0 = err_cnt;
    press(4'h7, 3);
    tick(7);
    @(negedge clock); DataIn = 4'h9; dav = 1'b1;
    @(negedge clock);
    @(negedge clock); TimerTrigger = 1'b1;
    @(negedge clock); TimerTrigger = 1'b0; dav = 1'b0;
    repeat (5) @(negedge clock);
    chk("wd_simul_no_err", err_cnt - e0, 0);
    chk("wd_simul_we", we_cnt - w0, 1);
    chk("wd_simul_we_data", last_we_data, 4'h9);
    chk("wd_simul_disp_addr", disp_addr, 4'h7);
    chk("wd_simul_disp_data", disp_data, 4'h9);
    chk("wd_simul_state", state_dbg, 3'd0);

    // Long hold gives one key event; key during commit is dropped
    w0 = we_cnt;
    press(4'h4, 50);
    chk("hold50_state", state_dbg, 3'd1);
    chk("hold50_no_we", we_cnt - w0, 0);
    data_key_until_we(4'h6, seen);
    chk("drop_we_seen", seen, 1'b1);
    DataIn = 4'hC;
    dav    = 1'b1;
    repeat (8) @(negedge clock);
    chk("drop_state_held", state_dbg, 3'd0);
    dav = 1'b0;
    repeat (4) @(negedge clock);
    chk("drop_state", state_dbg, 3'd0);
    chk("drop_we", we_cnt - w0, 1);
    chk("drop_disp_addr", disp_addr, 4'h4);
    chk("drop_disp_data", disp_data, 4'h6);

    // Reset asserted during W_COMMIT
    press(4'h8, 3);
    data_key_until_we(4'h1, seen);
    chk("rstmid_we_seen", seen, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_we", mem_if.mem_we, 1'b0);
    chk("rstmid_state", state_dbg, 3'd0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_mem_addr", mem_if.mem_addr, 4'h0);
    chk("rstmid_disp_valid", disp_valid, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("rstmid_after_state", state_dbg, 3'd0);
    chk("rstmid_after_we", mem_if.mem_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences a 16x4 synchronous RAM from the keypad and the timer tick. In write mode it takes two keypad digits (address, then data) and commits one RAM write. In read mode it scans the RAM from a keyed start address, advancing one location every SCAN_TICKS timer ticks, and presents address and data to the display. It sits between the keypad decoder (dav/DataIn), the timer (TimerTrigger), the RAM and the 7-segment display driver.

## Interface
- ADDR_W, 4: RAM address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 4: RAM data width; must equal keypad code width (4)
- SCAN_TICKS, 4: TimerTrigger ticks each read address is held on the display (≥1)
- TIMEOUT_TICKS, 8: TimerTrigger ticks allowed between address key and data key (≥1)

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- dav  in  1  keypad data-available; asynchronous level, high while key held
- DataIn  in  4  keypad code, stable while dav high
- TimerTrigger  in  1  one-cycle tick from timer, synchronous to clock
- mode  in  1  0 = write session, 1 = read session; sampled only in IDLE
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_we  out  1  RAM write enable, one-cycle pulse
- disp_addr  out  ADDR_W  address shown on display
- disp_data  out  DATA_W  data shown on display
- disp_valid  out  1  disp_addr/disp_data hold a completed read
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on write timeout
- state_dbg  out  3  current state encoding

## Operation
- dav passes a 2-flop synchronizer plus a third flop; key_evt = sync2 & ~sync3 (one cycle per press). DataIn is registered on the same edge as sync2.
- States (state_dbg): IDLE=0, W_DATA=1, W_COMMIT=2, R_ISSUE=3, R_LATCH=4, R_HOLD=5.
- IDLE: on key_evt, addr_reg ← key code. mode=0 → W_DATA, clear tick count. mode=1 → R_ISSUE, scan=1.
- W_DATA: on key_evt, data_reg ← key code → W_COMMIT. Otherwise count TimerTrigger; the tick that reaches TIMEOUT_TICKS → IDLE with err=1 for that cycle.
- W_COMMIT: mem_we=1, mem_addr=addr_reg, mem_wdata=data_reg for exactly one cycle → R_ISSUE with scan=0 (read-back).
- R_ISSUE: mem_addr=addr_reg, mem_we=0 → R_LATCH.
- R_LATCH: disp_addr ← addr_reg, disp_data ← mem_rdata, disp_valid ← 1. scan=0 → IDLE. scan=1 → R_HOLD, clear tick count.
- R_HOLD: key_evt → IDLE (abort; display keeps last values). Otherwise count TimerTrigger; the tick that reaches SCAN_TICKS sets addr_reg ← addr_reg+1 (wrap 2^ADDR_W−1 → 0) → R_ISSUE.
- key_evt in W_COMMIT, R_ISSUE or R_LATCH is dropped; it is not queued.
- key_evt and TimerTrigger in the same cycle: key_evt wins (R_HOLD aborts; W_DATA accepts data, no timeout).
- Tick counters are ⌈log2(max tick count+1)⌉ bits. They saturate and never wrap.
- mode changes outside IDLE are ignored.

## Timing
- Reset (reset=0 at an edge): state IDLE; mem_addr, mem_wdata, disp_addr, disp_data = 0; mem_we, disp_valid, busy, err = 0; synchronizer flops and counters = 0. Takes effect at that edge; outputs are valid the same cycle after the edge.
- Reset mid-operation (including W_COMMIT): mem_we is 0 from the reset edge onward. A partial session is discarded.
- dav rising before edge k: key_evt is high in the cycle after edge k+1. The FSM acts at edge k+2.
- Write latency: data key_evt edge → W_COMMIT (mem_we high 1 cycle) → R_ISSUE → R_LATCH. disp_valid and read-back data are updated 3 edges after the data-key acceptance edge.
- Scan period: 2 cycles (issue + latch) + SCAN_TICKS ticks per address.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: hold reset=0 for 3 cycles with dav toggling → all outputs 0, state_dbg=0, no mem_we.
- Write + read-back: mode=0; keys 0x5 then 0xA → single mem_we pulse with mem_addr=5, mem_wdata=A; then disp_addr=5, disp_data=A, disp_valid=1; return to IDLE.
- Scan with wrap: RAM preloaded with data = ~addr, mode=1, key 0xE, SCAN_TICKS=4 → displays (E,1), (F,0), (0,F), each held exactly 4 ticks. Key press → IDLE with (0,F) retained.
- Timeout: mode=0, key 0x3, no further key, 8 TimerTrigger ticks → err pulse of exactly 1 cycle on the 8th tick, IDLE, no mem_we.
- Simultaneous events: in R_HOLD, key_evt coincides with the SCAN_TICKS-th tick → IDLE, addr_reg not incremented. In W_DATA, the data key coincides with the 8th tick → write proceeds, no err.
- Dropped key and reset mid-write: a key during W_COMMIT is ignored, and one press produces exactly one key_evt even with dav held 50 cycles. reset=0 asserted in W_COMMIT → mem_we low from that edge, state IDLE.
